// File: rtl/fsm_rx_pkg.sv
// Shared definitions for the serial byte link (transmitter fsm and receiver fsm_rx).
// - state_t        : FSM state encoding, also driven onto the debug s port
// - PAR_*          : parity mode selectors for the PARITY parameter
// - FRAME_DATA_BITS: data bits per frame
package fsm_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned FRAME_DATA_BITS = 8;

endpackage

// File: rtl/fsm_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle-high line never looks like a start bit.
// Ports: clk, rst (async, active-high), din (raw line), dout (synchronized line)
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/fsm_rx.sv
// Serial receiver for frames produced by the fsm transmitter:
// idle-high, start bit 0, 8 data bits LSB-first, optional parity, STOP_BITS stop bits.
// Received bytes land in a one-entry buffer with valid/ack handshake.
// Ports:
//   clk, rst            clock, async active-high reset
//   rxd                 serial input
//   data, valid, ack    byte buffer and handshake
//   parity_err          parity mismatch for the byte in data
//   frame_err           a stop bit was sampled 0 for the byte in data
//   overrun             an unacknowledged byte was overwritten
//   s                   current FSM state (debug)
module fsm_rx
  import fsm_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY       = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] s
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] SAMPLE_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA  = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);
  localparam logic          ODD_MODE   = (PARITY == PAR_ODD);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cur_cnt, adv_cnt;
  logic            run, run_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            pe_pend, pe_pend_n;
  logic            fe_pend, fe_pend_n;
  logic            armed, armed_n;
  logic            sample;
  logic            done;
  logic            rxd_s;

  rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .dout (rxd_s)
  );

  assign s = state;

  // The start-detect cycle counts as timer position 0 without having been
  // loaded, so with CLKS_PER_BIT=1 (or 2) the detecting cycle is the sample.
  always_comb begin
    cur_cnt = (state == ST_IDLE && !run) ? '0 : cnt;
    sample  = (cur_cnt == SAMPLE_CNT);
    adv_cnt = (cur_cnt == LAST_CNT) ? '0 : cur_cnt + CW'(1);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_n     = run;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    pe_pend_n = pe_pend;
    fe_pend_n = fe_pend;
    armed_n   = armed | rxd_s;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run || (armed && !rxd_s)) begin
          cnt_n = adv_cnt;
          if (sample) begin
            run_n = 1'b0;
            if (!rxd_s) begin
              state_n   = ST_DATA;
              bit_cnt_n = '0;
              pe_pend_n = 1'b0;
              fe_pend_n = 1'b0;
            end
          end else begin
            run_n = 1'b1;
          end
        end else begin
          cnt_n = '0;
          run_n = 1'b0;
        end
      end

      ST_DATA: begin
        cnt_n = adv_cnt;
        if (sample) begin
          shreg_n = {rxd_s, shreg[7:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end

      ST_PARITY: begin
        cnt_n = adv_cnt;
        if (sample) begin
          pe_pend_n = (^shreg) ^ rxd_s ^ ODD_MODE;
          state_n   = ST_STOP;
        end
      end

      ST_STOP: begin
        cnt_n = adv_cnt;
        if (sample) begin
          if (!rxd_s) fe_pend_n = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            done      = 1'b1;
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            cnt_n     = '0;
            // A framing error disarms start detection until the line goes
            // high, so a held-low break yields one frame, not a stream.
            if (fe_pend_n) armed_n = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      run     <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      pe_pend <= 1'b0;
      fe_pend <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      run     <= run_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      pe_pend <= pe_pend_n;
      fe_pend <= fe_pend_n;
      armed   <= armed_n;
    end
  end

  // Output buffer: completion has priority over ack; a simultaneous ack
  // consumes the old byte, so no overrun is flagged for the new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      data       <= shreg;
      parity_err <= pe_pend;
      frame_err  <= fe_pend_n;
      valid      <= 1'b1;
      overrun    <= valid & ~ack;
    end else if (valid && ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_rx.sv
// Directed bench for fsm_rx: three instances (even parity, odd parity,
// 4 clocks per bit) driven by a serial frame generator; expected buffer
// contents are queued when frames are sent and popped on delivery.
module tb_fsm_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst;
  logic rxd_m, rxd_o, rxd_w;
  logic ack_m, ack_o, ack_w;
  logic [7:0] data_m, data_o, data_w;
  logic valid_m, valid_o, valid_w;
  logic pe_m, pe_o, pe_w;
  logic fe_m, fe_o, fe_w;
  logic ov_m, ov_o, ov_w;
  logic [1:0] s_m, s_o, s_w;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lb_bytes [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0,
                                8'h3C, 8'hC3, 8'h7E, 8'h81, 8'h12, 8'h34, 8'hDE, 8'hAD};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fsm_rx u_main (
    .clk(clk), .rst(rst), .rxd(rxd_m), .data(data_m), .valid(valid_m), .ack(ack_m),
    .parity_err(pe_m), .frame_err(fe_m), .overrun(ov_m), .s(s_m)
  );

  fsm_rx #(.PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .rxd(rxd_o), .data(data_o), .valid(valid_o), .ack(ack_o),
    .parity_err(pe_o), .frame_err(fe_o), .overrun(ov_o), .s(s_o)
  );

  fsm_rx #(.CLKS_PER_BIT(4)) u_slow (
    .clk(clk), .rst(rst), .rxd(rxd_w), .data(data_w), .valid(valid_w), .ack(ack_w),
    .parity_err(pe_w), .frame_err(fe_w), .overrun(ov_w), .s(s_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t get_obs(input int sel);
    case (sel)
      1:       return '{d: data_o, pe: pe_o, fe: fe_o, ov: ov_o};
      2:       return '{d: data_w, pe: pe_w, fe: fe_w, ov: ov_w};
      default: return '{d: data_m, pe: pe_m, fe: fe_m, ov: ov_m};
    endcase
  endfunction

  function automatic logic get_valid(input int sel);
    case (sel)
      1:       return valid_o;
      2:       return valid_w;
      default: return valid_m;
    endcase
  endfunction

  task automatic set_line(input int sel, input logic b);
    case (sel)
      1:       rxd_o = b;
      2:       rxd_w = b;
      default: rxd_m = b;
    endcase
  endtask

  task automatic set_ack(input int sel, input logic b);
    case (sel)
      1:       ack_o = b;
      2:       ack_w = b;
      default: ack_m = b;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit value; returns 1 time unit after the
  // first edge that follows the last stop-bit period.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic sbit, input int cpb);
    set_line(sel, 1'b0);
    cycles(cpb);
    for (int unsigned i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      cycles(cpb);
    end
    set_line(sel, pbit);
    cycles(cpb);
    set_line(sel, sbit);
    cycles(cpb);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e = '{d: d, pe: pe, fe: fe, ov: ov};
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int sel, input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (get_valid(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.timeout: observed valid=0 expected valid=1 within %0d cycles", tag, maxc);
    end
  endtask

  task automatic cmp_out(input int sel, input string tag);
    exp_t e, o;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.sb: observed delivery expected none queued", tag);
      return;
    end
    e = sb.pop_front();
    o = get_obs(sel);
    chk({tag, ".valid"}, 32'(get_valid(sel)), 32'd1);
    chk({tag, ".data"}, 32'(o.d), 32'(e.d));
    chk({tag, ".parity_err"}, 32'(o.pe), 32'(e.pe));
    chk({tag, ".frame_err"}, 32'(o.fe), 32'(e.fe));
    chk({tag, ".overrun"}, 32'(o.ov), 32'(e.ov));
  endtask

  task automatic ack_pulse(input int sel);
    set_ack(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ack(sel, 1'b0);
  endtask

  initial begin
    int quiet;
    rst = 1'b1;
    rxd_m = 1'b1; rxd_o = 1'b1; rxd_w = 1'b1;
    ack_m = 1'b0; ack_o = 1'b0; ack_w = 1'b0;

    // Reset state
    #2;
    chk("rst.data", 32'(data_m), 32'h0);
    chk("rst.valid", 32'(valid_m), 32'h0);
    chk("rst.flags", {29'd0, pe_m, fe_m, ov_m}, 32'h0);
    chk("rst.s", 32'(s_m), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(3);

    // 1: 0xA5 with exact latency, then ack
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1);
    chk("a5.lat1", 32'(valid_m), 32'd0);
    cycles(1);
    chk("a5.lat2", 32'(valid_m), 32'd0);
    cycles(1);
    cmp_out(0, "a5");
    ack_pulse(0);
    chk("a5.acked", 32'(valid_m), 32'd0);
    cycles(2);

    // 2: back-to-back loopback stream, consumer acks each byte
    for (int unsigned i = 0; i < 16; i++) push_exp(lb_bytes[i], 1'b0, 1'b0, 1'b0);
    fork
      begin
        for (int unsigned i = 0; i < 16; i++) send_frame(0, lb_bytes[i], ^lb_bytes[i], 1'b1, 1);
      end
      begin
        for (int unsigned j = 0; j < 16; j++) begin
          wait_valid(0, 40, "loop");
          cmp_out(0, "loop");
          ack_pulse(0);
        end
      end
    join
    cycles(3);

    // 3: parity error in even mode; same frame is correct in odd mode
    push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1);
    wait_valid(0, 10, "par_even");
    cmp_out(0, "par_even");
    ack_pulse(0);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1);
    wait_valid(1, 10, "par_odd");
    cmp_out(1, "par_odd");
    ack_pulse(1);
    cycles(2);

    // 4: frame error followed by a held-low break
    push_exp(8'h81, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1);
    wait_valid(0, 10, "brk");
    cmp_out(0, "brk");
    ack_pulse(0);
    quiet = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid_m || s_m != 2'd0) quiet++;
    end
    chk("brk.quiet", 32'(quiet), 32'd0);
    @(posedge clk);
    #1;
    set_line(0, 1'b1);
    cycles(3);
    push_exp(8'h42, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h42, 1'b0, 1'b1, 1);
    wait_valid(0, 10, "after_brk");
    cmp_out(0, "after_brk");
    ack_pulse(0);
    cycles(2);

    // 5a: overwrite without ack
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1, 1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1);
    cycles(2);
    cmp_out(0, "ovr");
    ack_pulse(0);
    chk("ovr.valid_clr", 32'(valid_m), 32'd0);
    chk("ovr.ovr_clr", 32'(ov_m), 32'd0);
    cycles(2);

    // 5b: ack lands exactly on the second completion cycle
    push_exp(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b1, 1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1);
    cycles(1);
    ack_m = 1'b1;
    cycles(1);
    ack_m = 1'b0;
    cmp_out(0, "ack_same");
    ack_pulse(0);
    chk("ack_same.clr", 32'(valid_m), 32'd0);
    cycles(2);

    // 6: reset mid-frame discards the partial byte
    set_line(0, 1'b0);
    cycles(1);
    repeat (4) begin
      set_line(0, 1'b1);
      cycles(1);
    end
    rst = 1'b1;
    cycles(2);
    chk("midrst.valid", 32'(valid_m), 32'd0);
    chk("midrst.s", 32'(s_m), 32'd0);
    rst = 1'b0;
    cycles(4);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
    wait_valid(0, 10, "midrst");
    cmp_out(0, "midrst");
    ack_pulse(0);

    // 6b: one-cycle glitch at 4 clocks per bit is a false start
    set_line(2, 1'b0);
    cycles(1);
    set_line(2, 1'b1);
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_w || s_w != 2'd0) quiet++;
    end
    chk("glitch.quiet", 32'(quiet), 32'd0);
    @(posedge clk);
    #1;
    push_exp(8'h96, 1'b0, 1'b0, 1'b0);
    send_frame(2, 8'h96, 1'b0, 1'b1, 4);
    wait_valid(2, 20, "slow");
    cmp_out(2, "slow");
    ack_pulse(2);
    chk("slow.clr", 32'(valid_w), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_rx.md
Name: fsm_rx

Overview:
Serial receiver that consumes the txd line of the existing byte transmitter (fsm) and rebuilds its bytes.
- Frame: idle-high, one start bit (0), 8 data bits LSB-first, an optional parity bit, then STOP_BITS stop bits (1).
- Sits directly downstream of fsm in loopback and board builds.
- Holds each received byte in a one-entry output buffer with a valid/ack handshake and error flags.

Parameters:
CLKS_PER_BIT, 1, clock cycles per serial bit (must be ≥1); 1 matches the transmitter's one-bit-per-clock rate
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
rxd  in  1  serial input; connects to fsm txd
data  out  8  last received byte
valid  out  1  data/flags hold an unacknowledged byte
ack  in  1  consumer takes byte; effective only while valid=1
parity_err  out  1  parity mismatch for the byte in data
frame_err  out  1  a stop bit was sampled 0 for the byte in data
overrun  out  1  an unacknowledged byte was overwritten
s  out  2  current state (debug, mirrors fsm's s port)

Behaviour:
- Reset (async, rst=1):
  - state IDLE, all counters 0.
  - data=0, valid=0, parity_err=0, frame_err=0, overrun=0.
  - Sync flops = 1. Armed = 1.
- Input path: rxd passes through a 2-flop synchronizer; all sampling uses the synchronizer output rxd_s.
- State encoding on s: IDLE=0, DATA=1, PARITY=2, STOP=3.
- Bit timer: counter 0..CLKS_PER_BIT-1. The sample point is count (CLKS_PER_BIT-1)/2.
- IDLE:
  - While armed, rxd_s=0 starts the timer.
  - At the sample point, if rxd_s=0 go to DATA; otherwise it is a false start and the block stays in IDLE.
  - With CLKS_PER_BIT=1, the detecting cycle is the start-bit sample.
- DATA: 8 samples, shifted in LSB-first. Then go to PARITY, or to STOP if PARITY=0.
- PARITY: one sample. Error when (XOR of the data bits XOR the sample) ≠ (PARITY==2). Then go to STOP.
- STOP:
  - STOP_BITS samples; any 0 sets the pending frame error.
  - After the last sample the frame completes and the block returns to IDLE.
  - After a frame error, armed=0. Armed is set again by the first rxd_s=1, so a break (line held 0) yields a single frame_err, not repeated frames.
- Completion (registered):
  - data, parity_err and frame_err are loaded together; valid=1.
  - Errors do not suppress delivery.
- Handshake:
  - ack with valid=1 and no completion in the same cycle: valid←0 and overrun←0 next edge.
  - ack with valid=0 is ignored.
- Completion while valid=1 and ack=0: the new byte overwrites and overrun←1. Overrun stays high until ack.
- Completion and ack in the same cycle: the new byte is loaded, valid stays 1, overrun←0.
- Latency (CLKS_PER_BIT=1): valid rises on the 3rd rising edge after the final stop bit first appears on rxd (2 sync + 1 output register). Back-to-back frames, with no idle bit between them, must be received.
- Reset mid-frame: the partial byte is discarded. After release, the block waits for a fresh start while the line is high.

Decomposition:
- Shared package: state encodings (IDLE/DATA/PARITY/STOP), the parity-mode constants (NONE/EVEN/ODD), and a FRAME_DATA_BITS=8 constant. fsm reuses these for its own s encoding.
- One natural sub-module: rx_sync, a 2-flop synchronizer with async reset to 1. The bit timer and FSM stay in fsm_rx.

Test Plan:
1. Defaults; send 0xA5 as rxd bits 0,1,0,1,0,0,1,0,1,0(par),1. Expect data=0xA5, valid=1 three edges after the stop bit, no error flags; ack → valid=0.
2. Loopback fsm→fsm_rx using the existing input.data stimulus (16 bytes). Every byte matches in order and no flag ever rises.
3. Send 0x3C with parity bit 1 (even mode). Expect data=0x3C, parity_err=1. Repeat with PARITY=2: parity bit 1 is correct.
4. Send 0x81 with stop bit 0, then hold rxd=0 for 20 cycles. Expect exactly one completion with frame_err=1, and no further valid until rxd returns high and a new frame arrives.
5. Send 0x11 and 0x22 back-to-back without ack. Expect data=0x22, overrun=1; ack clears valid and overrun. Repeat with ack pulsed exactly on the second completion cycle: data=0x22, valid=1, overrun=0.
6. Assert rst after the 4th data bit of 0xFF, release, then send 0x5A. Expect only 0x5A delivered. Also test CLKS_PER_BIT=4 with a 1-cycle 0 glitch on idle rxd: no frame starts.
